data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 150 +++++++++++++++
 tb/tb_data_mem_responder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data memory responder for the memory stage: RV32I loads/stores, WAIT_CYCLES wait states.
// Optional DMEM_MISALIGN_CHECK_EN rejects misaligned halfword/word accesses.
module data_mem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int AW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t state, state_nx;
   logic [3:0]  cnt, cnt_nx;
   logic        we_q;
   logic [2:0]  f3_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;

   logic [31:0] mem [DEPTH_WORDS];

   logic [AW-1:0] idx;
   logic [31:0]   word, bsh, hsh, rd, wd, bm;
   logic [3:0]    mask;
   logic          illegal, misalign, err, fire, wr_en;
   logic          unused;

   assign idx    = addr_q[AW+1:2];
   assign unused = ^addr_q[31:AW+2];
   assign word   = mem[idx];
   assign bsh    = word >> {addr_q[1:0], 3'b000};
   assign hsh    = word >> {addr_q[1], 4'b0000};
   assign bm     = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};

   always_comb begin
      rd      = '0;
      wd      = '0;
      mask    = '0;
      illegal = 1'b0;
      unique case (f3_q)
         3'b000: begin
            rd   = {{24{bsh[7]}}, bsh[7:0]};
            mask = 4'b0001 << addr_q[1:0];
            wd   = {4{wdata_q[7:0]}};
         end
         3'b001: begin
            rd   = {{16{hsh[15]}}, hsh[15:0]};
            mask = addr_q[1] ? 4'b1100 : 4'b0011;
            wd   = {2{wdata_q[15:0]}};
         end
         3'b010: begin
            rd   = word;
            mask = 4'b1111;
            wd   = wdata_q;
         end
         3'b100: begin
            rd      = {24'b0, bsh[7:0]};
            illegal = we_q;
         end
         3'b101: begin
            rd      = {16'b0, hsh[15:0]};
            illegal = we_q;
         end
         default: illegal = 1'b1;
      endcase
   end

`ifdef DMEM_MISALIGN_CHECK_EN
   assign misalign = (f3_q[1:0] == 2'b01 && addr_q[0]) ||
                     (f3_q[1:0] == 2'b10 && addr_q[1:0] != 2'b00);
`else
   assign misalign = 1'b0;
`endif

   assign err   = illegal | misalign;
   assign fire  = (state == WAIT) && (cnt == 4'(WAIT_CYCLES));
   assign wr_en = fire && we_q && !err && rst_n;

   assign req_ready = (state == IDLE);

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      unique case (state)
         IDLE: begin
            if (req_valid) begin
               state_nx = WAIT;
               cnt_nx   = '0;
            end
         end
         WAIT: begin
            if (fire) state_nx = RESP;
            else      cnt_nx   = cnt + 4'd1;
         end
         RESP: begin
            if (resp_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (fire) begin
            resp_valid <= 1'b1;
            resp_err   <= err;
            resp_rdata <= (err || we_q) ? '0 : rd;
         end else if (state == RESP && resp_ready) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
         end
      end
   end

   // Request fields are captured only on acceptance; no reset needed.
   always_ff @(posedge clk) begin
      if (state == IDLE && req_valid) begin
         we_q    <= req_we;
         f3_q    <= req_funct3;
         addr_q  <= req_addr;
         wdata_q <= req_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[idx] <= (word & ~bm) | (wd & bm);
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench for data_mem_responder against a byte-array model.
// Covers latency, byte lanes, backpressure, illegal funct3, wrap and reset abort.
module tb_data_mem_responder;

   localparam int W  = 2;
   localparam int DW = 1024;
   localparam int NB = DW * 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_rdata;
   logic        resp_err;

   int total = 0;
   int bad   = 0;

   byte unsigned mb [NB];
   bit           kb [NB];

   data_mem_responder #(.DEPTH_WORDS(DW), .WAIT_CYCLES(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_funct3(req_funct3),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic void model(input bit we, input bit [2:0] f3,
                                 input bit [31:0] a, input bit [31:0] wdat,
                                 output bit [31:0] rd, output bit err,
                                 output bit known);
      int size, base, off;
      bit sgn;
      bit [31:0] v;
      rd = 0; err = 0; known = 1; size = 4; sgn = 0;
      case (f3)
         3'd0: begin size = 1; sgn = 1; end
         3'd1: begin size = 2; sgn = 1; end
         3'd2: size = 4;
         3'd4: begin size = 1; err = we; end
         3'd5: begin size = 2; err = we; end
         default: err = 1;
      endcase
      if (err) return;
      off = int'(a % 32'(NB));
`ifdef DMEM_MISALIGN_CHECK_EN
      if (off % size != 0) begin
         err = 1;
         return;
      end
`endif
      base = off - (off % size);
      if (we) begin
         for (int i = 0; i < size; i++) begin
            mb[base + i] = wdat[8*i +: 8];
            kb[base + i] = 1;
         end
         return;
      end
      v = 0;
      for (int i = 0; i < size; i++) begin
         v = v | (32'(mb[base + i]) << (8 * i));
         known = known & kb[base + i];
      end
      if (sgn && size < 4 && v[8*size-1])
         v = v | (32'hFFFF_FFFF << (8 * size));
      rd = v;
   endfunction

   task automatic txn(input bit we, input bit [2:0] f3, input bit [31:0] a,
                      input bit [31:0] wdat, input int hold,
                      input string tag, output logic [31:0] got);
      bit [31:0] erd;
      bit eerr, kn;
      int n;
      logic [31:0] held;
      @(negedge clk);
      req_valid = 1; req_we = we; req_funct3 = f3;
      req_addr = a; req_wdata = wdat;
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_rdy"}, 32'(req_ready), 32'd1);
      @(posedge clk);
      model(we, f3, a, wdat, erd, eerr, kn);
      #1;
      req_valid = 0;
      req_we = 1'($urandom);
      req_funct3 = 3'($urandom);
      req_addr = $urandom;
      req_wdata = $urandom;
      n = 0;
      do begin
         @(posedge clk);
         n++;
         #1;
      end while (!resp_valid && n < 40);
      check({tag, "_lat"}, 32'(n), 32'(W + 1));
      check({tag, "_err"}, 32'(resp_err), 32'(eerr));
      if (kn) check({tag, "_rd"}, resp_rdata, erd);
      got = resp_rdata;
      held = resp_rdata;
      repeat (hold) begin
         @(posedge clk);
         #1;
         check({tag, "_hv"}, 32'(resp_valid), 32'd1);
         check({tag, "_hd"}, resp_rdata, held);
         check({tag, "_hr"}, 32'(req_ready), 32'd0);
      end
      @(negedge clk);
      resp_ready = 1;
      @(posedge clk);
      #1;
      resp_ready = 0;
      check({tag, "_idle"}, 32'(req_ready), 32'd1);
      check({tag, "_vlo"}, 32'(resp_valid), 32'd0);
   endtask

   initial begin
      logic [31:0] got;
      bit [31:0] a;
      bit [2:0] f3;
      bit we;

      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 32'(resp_valid), 32'd0);
      check("rst_err", 32'(resp_err), 32'd0);
      check("rst_rdata", resp_rdata, 32'd0);
      check("rst_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      rst_n = 1;

      for (int i = 0; i < 16; i++)
         txn(1, 3'd2, 32'(i * 4), $urandom, 0, "init", got);
      txn(1, 3'd2, 32'h40, 32'hCAFE_F00D, 0, "init40", got);

      txn(1, 3'd2, 32'h10, 32'hDEAD_BEEF, 0, "sw10", got);
      txn(0, 3'd2, 32'h10, 0, 0, "lw10", got);
      check("lw10_k", got, 32'hDEAD_BEEF);

      txn(1, 3'd2, 32'h10, 32'h0, 0, "sw10z", got);
      txn(1, 3'd0, 32'h13, 32'h80, 0, "sb13", got);
      txn(0, 3'd0, 32'h13, 0, 0, "lb13", got);
      check("lb13_k", got, 32'hFFFF_FF80);
      txn(0, 3'd4, 32'h13, 0, 0, "lbu13", got);
      check("lbu13_k", got, 32'h0000_0080);
      txn(0, 3'd2, 32'h10, 0, 5, "lw10b", got);
      check("lw10b_k", got, 32'h8000_0000);

      txn(0, 3'd1, 32'h22, 0, 0, "lh22", got);
      txn(1, 3'd2, 32'h21, 32'h1357_9BDF, 0, "sw21", got);
      txn(0, 3'd2, 32'h20, 0, 0, "lw20", got);

      txn(0, 3'd3, 32'h10, 0, 0, "f3_011", got);
      check("f3_011_k", got, 32'h0);
      txn(1, 3'd2, 32'h1000, 32'hA5A5_5A5A, 0, "sw1000", got);
      txn(0, 3'd2, 32'h0, 0, 0, "lw0", got);
      check("lw0_wrap", got, 32'hA5A5_5A5A);

      @(negedge clk);
      req_valid = 1; req_we = 1; req_funct3 = 3'd2;
      req_addr = 32'h40; req_wdata = 32'h1234_5678;
      @(posedge clk);
      #1;
      req_valid = 0;
      @(negedge clk);
      rst_n = 0;
      @(posedge clk);
      #1;
      check("abort_valid", 32'(resp_valid), 32'd0);
      check("abort_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      rst_n = 1;
      txn(0, 3'd2, 32'h40, 0, 0, "lw40", got);
      check("lw40_old", got, 32'hCAFE_F00D);

      for (int i = 0; i < 250; i++) begin
         we = 1'($urandom);
         f3 = 3'($urandom);
         a = $urandom & 32'hFFFF_F03F;
         txn(we, f3, a, $urandom, $urandom_range(0, 2), "rnd", got);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
